// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode-set-2 constants: prefix bytes, parser states, pair modes, game keymap.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef logic [1:0] parser_state_t;
    localparam parser_state_t IDLE     = 2'd0;
    localparam parser_state_t GOT_E0   = 2'd1;
    localparam parser_state_t GOT_F0   = 2'd2;
    localparam parser_state_t GOT_E0F0 = 2'd3;

    localparam int unsigned PAIR_PASS   = 0;
    localparam int unsigned PAIR_LAST   = 1;
    localparam int unsigned PAIR_CANCEL = 2;

    localparam int unsigned GAME_NUM_KEYS = 4;
    localparam logic [GAME_NUM_KEYS*9-1:0] GAME_KEYMAP = {9'h01D, 9'h01B, 9'h043, 9'h042};

endpackage

// File: rtl/ps2_prefix_parser.sv
// E0/F0 prefix parser with prefix timeout; presents completed codes one cycle after the byte.
module ps2_prefix_parser
    import ps2_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 50_000
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       code_valid,
    output logic       code_ext,
    output logic       code_break,
    output logic [7:0] code,
    output logic       prefix_drop
);

    localparam int unsigned CW = $clog2(PREFIX_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);

    parser_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          code_valid_q, code_valid_d;
    logic          code_ext_q, code_ext_d;
    logic          code_break_q, code_break_d;
    logic [7:0]    code_q, code_d;
    logic          drop_q, drop_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        code_valid_d = 1'b0;
        code_ext_d   = code_ext_q;
        code_break_d = code_break_q;
        code_d       = code_q;
        drop_d       = 1'b0;
        if (byte_valid) begin
            cnt_d  = '0;
            code_d = byte_data;
            unique case (state_q)
                IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_d = GOT_E0;
                    end else if (byte_data == PS2_BRK) begin
                        state_d = GOT_F0;
                    end else begin
                        code_valid_d = 1'b1;
                        code_ext_d   = 1'b0;
                        code_break_d = 1'b0;
                    end
                end
                GOT_E0: begin
                    if (byte_data == PS2_BRK) begin
                        state_d = GOT_E0F0;
                    end else if (byte_data != PS2_EXT) begin
                        state_d      = IDLE;
                        code_valid_d = 1'b1;
                        code_ext_d   = 1'b1;
                        code_break_d = 1'b0;
                    end
                end
                GOT_F0, GOT_E0F0: begin
                    // A prefix byte here is malformed and simply abandons the sequence.
                    state_d = IDLE;
                    if (byte_data != PS2_EXT && byte_data != PS2_BRK) begin
                        code_valid_d = 1'b1;
                        code_ext_d   = (state_q == GOT_E0F0);
                        code_break_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                drop_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            code_valid_q <= 1'b0;
            code_ext_q   <= 1'b0;
            code_break_q <= 1'b0;
            code_q       <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_valid_q <= code_valid_d;
            code_ext_q   <= code_ext_d;
            code_break_q <= code_break_d;
            code_q       <= code_d;
            drop_q       <= drop_d;
        end
    end

    assign code_valid  = code_valid_q;
    assign code_ext    = code_ext_q;
    assign code_break  = code_break_q;
    assign code        = code_q;
    assign prefix_drop = drop_q;

endmodule

// File: rtl/key_state_tracker.sv
// Tracks held state of mapped PS/2 keys, emits press/release events and resolves
// opposing-direction key pairs.
module key_state_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned             NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0]   KEYMAP         = GAME_KEYMAP,
    parameter int unsigned             PAIR_MODE      = 1,
    parameter int unsigned             PREFIX_TIMEOUT = 50_000
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    input  logic                        flush,
    output logic [NUM_KEYS-1:0]         held,
    output logic [NUM_KEYS-1:0]         dir,
    output logic                        evt_valid,
    output logic [$clog2(NUM_KEYS)-1:0] evt_idx,
    output logic                        evt_make,
    output logic                        prefix_drop
);

    localparam int unsigned IW = $clog2(NUM_KEYS);
    localparam int unsigned NP = NUM_KEYS / 2;

    logic          code_valid, code_ext, code_break;
    logic [7:0]    code;
    logic [NUM_KEYS-1:0] sel;
    logic          found;

    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NP-1:0]       last_q, last_d;
    logic                evt_valid_q, evt_valid_d;
    logic [IW-1:0]       evt_idx_q, evt_idx_d;
    logic                evt_make_q, evt_make_d;
    logic                flush_q;

    ps2_prefix_parser #(
        .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
    ) u_parser (
        .clk        (clk),
        .rst_b      (rst_b),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .code_valid (code_valid),
        .code_ext   (code_ext),
        .code_break (code_break),
        .code       (code),
        .prefix_drop(prefix_drop)
    );

    // Lowest matching keymap index wins; entry 0 sits in the MSBs.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (!found && KEYMAP[(NUM_KEYS-1-i)*9 +: 9] == {code_ext, code}) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // flush_q kills the code of a byte that arrived alongside flush.
    always_comb begin
        held_d      = held_q;
        last_d      = last_q;
        evt_valid_d = 1'b0;
        evt_idx_d   = evt_idx_q;
        evt_make_d  = evt_make_q;
        if (flush) begin
            held_d = '0;
            last_d = '0;
        end else if (code_valid && !flush_q) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                if (sel[i] && (held_q[i] == code_break)) begin
                    held_d[i]   = !code_break;
                    evt_valid_d = 1'b1;
                    evt_idx_d   = IW'(i);
                    evt_make_d  = !code_break;
                    if (!code_break) begin
                        last_d[i/2] = (i % 2 == 1);
                    end
                end
            end
        end
    end

    always_comb begin
        dir = held_q;
        for (int k = 0; k < int'(NP); k++) begin
            if (held_q[2*k] && held_q[2*k+1]) begin
                if (PAIR_MODE == PAIR_LAST) begin
                    dir[2*k]   = !last_q[k];
                    dir[2*k+1] = last_q[k];
                end else if (PAIR_MODE == PAIR_CANCEL) begin
                    dir[2*k]   = 1'b0;
                    dir[2*k+1] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            held_q      <= '0;
            last_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            evt_make_q  <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            held_q      <= held_d;
            last_q      <= last_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            evt_make_q  <= evt_make_d;
            flush_q     <= flush;
        end
    end

    assign held      = held_q;
    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign evt_make  = evt_make_q;

endmodule

// File: tb/tb_key_state_tracker.sv
// Scoreboard bench: two trackers (last-wins and cancel modes) share one byte stream.
module tb_key_state_tracker;

    localparam int unsigned NK = 6;
    localparam int unsigned TO = 20;
    localparam int unsigned IW = 3;
    localparam logic [NK*9-1:0] MAP =
        {9'h01D, 9'h01B, 9'h043, 9'h042, 9'h175, 9'h172};

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          flush = 1'b0;

    logic [NK-1:0] held1, dir1, held2, dir2;
    logic          evt_valid1, evt_make1, prefix_drop1;
    logic          evt_valid2, evt_make2, prefix_drop2;
    logic [IW-1:0] evt_idx1, evt_idx2;

    // Expected-event FIFO: main writes at exp_wr, monitor reads at exp_rd.
    logic [IW-1:0] exp_idx [64];
    logic          exp_make [64];
    int            exp_wr = 0;
    int            exp_rd = 0;
    int            drop_exp = 0;
    int            drop_seen = 0;

    logic          chk_req = 1'b0;
    logic          chk_rst = 1'b0;
    string         chk_name = "";
    logic [NK-1:0] chk_held = '0;
    logic [NK-1:0] chk_dir1 = '0;
    logic [NK-1:0] chk_dir2 = '0;
    logic          done = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_state_tracker #(
        .NUM_KEYS(NK), .KEYMAP(MAP), .PAIR_MODE(1), .PREFIX_TIMEOUT(TO)
    ) dut1 (
        .clk(clk), .rst_b(rst_b), .byte_valid(byte_valid), .byte_data(byte_data),
        .flush(flush), .held(held1), .dir(dir1), .evt_valid(evt_valid1),
        .evt_idx(evt_idx1), .evt_make(evt_make1), .prefix_drop(prefix_drop1)
    );

    key_state_tracker #(
        .NUM_KEYS(NK), .KEYMAP(MAP), .PAIR_MODE(2), .PREFIX_TIMEOUT(TO)
    ) dut2 (
        .clk(clk), .rst_b(rst_b), .byte_valid(byte_valid), .byte_data(byte_data),
        .flush(flush), .held(held2), .dir(dir2), .evt_valid(evt_valid2),
        .evt_idx(evt_idx2), .evt_make(evt_make2), .prefix_drop(prefix_drop2)
    );

    // Monitor: sole owner of the counters and the summary line.
    always @(negedge clk) begin
        if (evt_valid1) begin
            checks++;
            if (exp_rd >= exp_wr) begin
                errors++;
                $display("FAIL evt: unexpected event idx=%0d make=%0d, required no event",
                         evt_idx1, evt_make1);
            end else begin
                if (evt_idx1 !== exp_idx[exp_rd] || evt_make1 !== exp_make[exp_rd]) begin
                    errors++;
                    $display("FAIL evt[%0d]: got idx=%0d make=%0d, required idx=%0d make=%0d",
                             exp_rd, evt_idx1, evt_make1, exp_idx[exp_rd], exp_make[exp_rd]);
                end
                exp_rd++;
            end
        end
        if (prefix_drop1) begin
            checks++;
            if (drop_seen >= drop_exp) begin
                errors++;
                $display("FAIL prefix_drop: got unexpected pulse, required none");
            end
            drop_seen++;
        end
        if (chk_req) begin
            checks++;
            if (held1 !== chk_held || held2 !== chk_held || dir1 !== chk_dir1 ||
                dir2 !== chk_dir2 ||
                (chk_rst && (evt_idx1 !== '0 || evt_make1 !== 1'b0 ||
                             evt_valid1 !== 1'b0 || prefix_drop1 !== 1'b0))) begin
                errors++;
                $display("FAIL %s: got held=%b/%b dir1=%b dir2=%b, required held=%b dir1=%b dir2=%b",
                         chk_name, held1, held2, dir1, dir2, chk_held, chk_dir1, chk_dir2);
            end
        end
        if (done) begin
            checks++;
            if (exp_rd != exp_wr) begin
                errors++;
                $display("FAIL evt_count: got %0d events, required %0d", exp_rd, exp_wr);
            end
            checks++;
            if (drop_seen != drop_exp) begin
                errors++;
                $display("FAIL drop_count: got %0d pulses, required %0d", drop_seen, drop_exp);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic push_evt(input int idx, input logic make);
        exp_idx[exp_wr]  = IW'(idx);
        exp_make[exp_wr] = make;
        exp_wr++;
    endtask

    task automatic expect_state(input string name, input logic [NK-1:0] h,
                                input logic [NK-1:0] d1, input logic [NK-1:0] d2,
                                input logic rst_fields);
        tick(2);
        chk_name = name;
        chk_held = h;
        chk_dir1 = d1;
        chk_dir2 = d2;
        chk_rst  = rst_fields;
        chk_req  = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    initial begin
        tick(3);
        rst_b = 1'b1;
        expect_state("reset", 6'b000000, 6'b000000, 6'b000000, 1'b1);

        send(8'h1D); push_evt(0, 1'b1);
        expect_state("make_1d", 6'b000001, 6'b000001, 6'b000001, 1'b0);
        send(8'hF0); send(8'h1D); push_evt(0, 1'b0);
        expect_state("break_1d", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        send(8'hE0); send(8'h75); push_evt(4, 1'b1);
        expect_state("make_e075", 6'b010000, 6'b010000, 6'b010000, 1'b0);
        send(8'h75);
        expect_state("plain_75", 6'b010000, 6'b010000, 6'b010000, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h75); push_evt(4, 1'b0);
        expect_state("break_e075", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        send(8'h1D); push_evt(0, 1'b1);
        send(8'h1B); push_evt(1, 1'b1);
        expect_state("pair_newer", 6'b000011, 6'b000010, 6'b000000, 1'b0);
        send(8'hF0); send(8'h1B); push_evt(1, 1'b0);
        expect_state("pair_release_newer", 6'b000001, 6'b000001, 6'b000001, 1'b0);

        send(8'hF0); send(8'h1D); push_evt(0, 1'b0);
        send(8'h1D); push_evt(0, 1'b1);
        send(8'h1D); send(8'h1D);
        expect_state("typematic", 6'b000001, 6'b000001, 6'b000001, 1'b0);

        send(8'hF0); send(8'h1D); push_evt(0, 1'b0);
        send(8'h1B); push_evt(1, 1'b1);
        send(8'h1D); push_evt(0, 1'b1);
        expect_state("pair_older_last0", 6'b000011, 6'b000001, 6'b000000, 1'b0);
        send(8'h43); push_evt(2, 1'b1);
        expect_state("three_held", 6'b000111, 6'b000101, 6'b000100, 1'b0);

        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        expect_state("flush", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        send(8'hF0); drop_exp++;
        tick(TO + 3);
        send(8'h1D); push_evt(0, 1'b1);
        expect_state("after_drop", 6'b000001, 6'b000001, 6'b000001, 1'b0);

        // Next byte lands exactly on the timeout cycle and must win.
        send(8'hF0);
        tick(TO - 2);
        send(8'h1D); push_evt(0, 1'b0);
        expect_state("timeout_edge", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        send(8'hE0);
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        send(8'h75);
        expect_state("reset_mid", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        send(8'hE0); send(8'h75); push_evt(4, 1'b1);
        expect_state("after_reset_ext", 6'b010000, 6'b010000, 6'b010000, 1'b0);

        tick(3);
        done = 1'b1;
    end

endmodule
